// File: rtl/up_access_master.sv
// up_access_master: single-outstanding host request to strobed upen/upws/uprs port access bridge
//
// Optional feature macro: UP_ACC_TIMEOUT_EN (no-response timeout abort with herr/err_cnt)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   hvld/hrdy/hwr/haddr/hwdata   host request (accepted on hvld & hrdy)
//   hdone/hrdata/herr        one-cycle completion pulse with read data and timeout flag
//   err_cnt                  saturating timeout abort count
//   upen/upws/uprs/upa/updi  port access outputs
//   updo/uprdy               port read data and completion pulse
module up_access_master #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hvld,
  output logic               hrdy,
  input  logic               hwr,
  input  logic [ADDRBIT-1:0] haddr,
  input  logic [WIDTH-1:0]   hwdata,
  output logic               hdone,
  output logic [WIDTH-1:0]   hrdata,
  output logic               herr,
  output logic [7:0]         err_cnt,
  output logic               upen,
  output logic               upws,
  output logic               uprs,
  output logic [ADDRBIT-1:0] upa,
  output logic [WIDTH-1:0]   updi,
  input  logic [WIDTH-1:0]   updo,
  input  logic               uprdy
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, GAP} state_t;
  state_t state, state_nxt;
  logic dir;
  logic done_ok;
  logic tmo;
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end
  assign hrdy = state == IDLE;
  assign upen = state == STROBE || state == WAIT;
  assign upws = state == STROBE && dir;
  assign uprs = state == STROBE && !dir;
  // hdone is exactly the GAP cycle, one cycle after the completing edge
  assign hdone = state == GAP;
  // uprdy during the strobe cycle also completes the access
  assign done_ok = upen && uprdy;
`ifdef UP_ACC_TIMEOUT_EN
  logic [15:0] cnt;
  // counter holds the number of completed WAIT cycles, so the TIMEOUT-th WAIT cycle aborts;
  // uprdy in that same cycle takes priority
  assign tmo = state == WAIT && !uprdy && cnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      herr <= 1'b0;
      err_cnt <= '0;
    end else begin
      cnt <= state == STROBE ? '0 : state == WAIT ? cnt + 16'd1 : cnt;
      if (done_ok || tmo) herr <= tmo;
      if (tmo && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign tmo = 1'b0;
  assign herr = 1'b0;
  assign err_cnt = '0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE   ? (hvld ? STROBE : IDLE) :
                state == STROBE ? (uprdy ? GAP : WAIT) :
                state == WAIT   ? (uprdy || tmo ? GAP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upa <= '0;
      updi <= '0;
      dir <= 1'b0;
      hrdata <= '0;
    end else begin
      if (hrdy && hvld) begin
        upa <= haddr;
        updi <= hwdata;
        dir <= hwr;
      end
      if (done_ok) hrdata <= dir ? '0 : updo;
      else if (tmo) hrdata <= '0;
    end
  end
endmodule

// File: tb/tb_up_access_master.sv
// tb_up_access_master: directed scoreboard bench for up_access_master with a delayed-response port model
module tb_up_access_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hvld = 1'b0;
  logic hwr = 1'b0;
  logic [4:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] updo = '0;
  logic uprdy = 1'b0;
  logic hrdy, hdone, herr, upen, upws, uprs;
  logic [31:0] hrdata, updi;
  logic [7:0] err_cnt;
  logic [4:0] upa;
  typedef struct packed {logic [31:0] d; logic e;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
  int rs_cnt = 0, ws_cnt = 0, done_cnt = 0;
  logic resp_en = 1'b1;
  int resp_dly = 7;
  logic [31:0] resp_data = '0;
  always #5 clk = ~clk;
  up_access_master #(.ADDRBIT(5), .WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .hvld(hvld), .hrdy(hrdy), .hwr(hwr), .haddr(haddr),
    .hwdata(hwdata), .hdone(hdone), .hrdata(hrdata), .herr(herr), .err_cnt(err_cnt),
    .upen(upen), .upws(upws), .uprs(uprs), .upa(upa), .updi(updi), .updo(updo), .uprdy(uprdy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (upen) begin
      if (lo_run > 0) last_lo = lo_run;
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
      lo_run++;
    end
    if (uprs) rs_cnt++;
    if (upws) ws_cnt++;
    if (rst && hdone) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed hdone with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_hrdata", hrdata, e.d);
        check("sb_herr", {31'b0, herr}, {31'b0, e.e});
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rst && resp_en && (uprs || upws)) begin
      repeat (resp_dly) @(posedge clk);
      #1;
      uprdy = 1'b1;
      updo = resp_data;
      @(posedge clk);
      #1;
      uprdy = 1'b0;
    end
  end
  task automatic clr_cnt();
    rs_cnt = 0;
    ws_cnt = 0;
    done_cnt = 0;
  endtask
  task automatic wait_rdy();
    int n = 0;
    while (!hrdy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("hrdy_wait", {31'b0, n < 50}, 32'd1);
  endtask
  task automatic access(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    @(negedge clk);
    wait_rdy();
    clr_cnt();
    hvld = 1'b1;
    hwr = wr;
    haddr = a;
    hwdata = d;
    q.push_back('{exp_d, exp_e});
    @(posedge clk);
    #1;
    hvld = 1'b0;
    while (!hdone && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_wait", {31'b0, n < 200}, 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    check("rst_hrdy", {31'b0, hrdy}, 32'd1);
    check("rst_upen", {31'b0, upen}, 32'd0);
    check("rst_hdone", {31'b0, hdone}, 32'd0);
    check("rst_upa", {27'b0, upa}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    resp_dly = 7;
    resp_data = 32'hDEADBEEF;
    access(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rd_upa", {27'b0, upa}, 32'd5);
    check("rd_uprs_pulses", rs_cnt, 32'd1);
    check("rd_upws_pulses", ws_cnt, 32'd0);
    check("rd_upen_cycles", last_hi, 32'd8);
    @(negedge clk);
    #1;
    check("rd_hdone_pulses", done_cnt, 32'd1);
    check("rd_hrdy_back", {31'b0, hrdy}, 32'd1);
    check("rd_hrdata_hold", hrdata, 32'hDEADBEEF);
    resp_dly = 3;
    resp_data = 32'hAAAA5555;
    access(1'b1, 5'h1F, 32'h12345678, 32'h0, 1'b0);
    check("wr_upa", {27'b0, upa}, 32'h1F);
    check("wr_updi", updi, 32'h12345678);
    check("wr_upws_pulses", ws_cnt, 32'd1);
    check("wr_uprs_pulses", rs_cnt, 32'd0);
    check("wr_upen_cycles", last_hi, 32'd4);
    @(negedge clk);
    wait_rdy();
    clr_cnt();
    resp_dly = 2;
    resp_data = 32'h0BADF00D;
    hvld = 1'b1;
    hwr = 1'b0;
    haddr = 5'd3;
    q.push_back('{32'h0BADF00D, 1'b0});
    @(posedge clk);
    #1;
    hwr = 1'b1;
    haddr = 5'd7;
    hwdata = 32'h0000CAFE;
    q.push_back('{32'h0, 1'b0});
    for (int n = 0; n < 50 && done_cnt < 1; n++) begin
      @(negedge clk);
      #1;
    end
    wait_rdy();
    @(posedge clk);
    #1;
    hvld = 1'b0;
    for (int n = 0; n < 50 && done_cnt < 2; n++) begin
      @(negedge clk);
      #1;
    end
    check("b2b_hdone_pulses", done_cnt, 32'd2);
    check("b2b_upen_low_cycles", last_lo, 32'd2);
    check("b2b_upa", {27'b0, upa}, 32'd7);
    check("b2b_updi", updi, 32'h0000CAFE);
`ifdef UP_ACC_TIMEOUT_EN
    resp_en = 1'b0;
    access(1'b0, 5'd9, 32'h0, 32'h0, 1'b0 | 1'b1);
    check("tmo_upen_cycles", last_hi, 32'd5);
    check("tmo_err_cnt", {24'b0, err_cnt}, 32'd1);
    resp_en = 1'b1;
    resp_dly = 4;
    resp_data = 32'h13579BDF;
    access(1'b0, 5'd2, 32'h0, 32'h13579BDF, 1'b0);
    check("tie_err_cnt", {24'b0, err_cnt}, 32'd1);
    resp_en = 1'b0;
    for (int i = 0; i < 256; i++) access(1'b0, 5'd1, 32'h0, 32'h0, 1'b1);
    check("sat_err_cnt", {24'b0, err_cnt}, 32'd255);
    resp_en = 1'b1;
`else
    check("noto_err_cnt", {24'b0, err_cnt}, 32'd0);
    check("noto_herr", {31'b0, herr}, 32'd0);
`endif
    resp_en = 1'b0;
    @(negedge clk);
    wait_rdy();
    hvld = 1'b1;
    hwr = 1'b0;
    haddr = 5'd4;
    @(posedge clk);
    #1;
    hvld = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_upen", {31'b0, upen}, 32'd0);
    check("arst_uprs", {31'b0, uprs}, 32'd0);
    check("arst_hdone", {31'b0, hdone}, 32'd0);
    check("arst_hrdy", {31'b0, hrdy}, 32'd1);
    check("arst_upa", {27'b0, upa}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    resp_en = 1'b1;
    resp_dly = 7;
    resp_data = 32'h600DCAFE;
    access(1'b0, 5'd6, 32'h0, 32'h600DCAFE, 1'b0);
    check("post_rst_upa", {27'b0, upa}, 32'd6);
    repeat (3) @(negedge clk);
    check("sb_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
